// File: rtl/serial_adder_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl_pkg
//   Shared definitions for the bit-serial adder controller.
//   - state_t    : controller state encoding (IDLE=0, RUN=1, DONE=2)
//   - cnt_width  : bit-counter width for a given operand width.
//                  One extra bit keeps W=1 and power-of-two W representable.
// ---------------------------------------------------------------------------
package serial_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
//   Single-bit full adder used as the serial bit cell.
//   Ports:
//     a, b, cin : operand bits and carry-in
//     sum       : a ^ b ^ cin
//     cout      : majority(a, b, cin)
// ---------------------------------------------------------------------------
module full_adder (
  output logic sum,
  output logic cout,
  input  logic a,
  input  logic b,
  input  logic cin
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl
//   Bit-serial adder: runs one full_adder over a W-bit operand pair, LSB
//   first, one bit per clock, with a carry flop closing the loop.
//   Result {cout,sum} == a + b + cin, registered and held until the next
//   completion.
//
//   Handshake: start is sampled only in IDLE; an accepted start captures
//   a/b/cin on that edge (they may change freely afterwards). busy is high
//   for the W RUN cycles, then done pulses high for exactly one cycle, from
//   which sum/cout are valid. start while busy or done is dropped, not queued.
//
//   Ports:
//     clk, rst_n      : clock, asynchronous active-low reset
//     start           : operation request
//     a, b [W-1:0]    : operands
//     cin             : carry-in
//     busy            : high in RUN
//     done            : one-cycle completion pulse
//     sum [W-1:0]     : registered result
//     cout            : registered carry-out
//     state_o [1:0]   : current controller state (debug visibility)
// ---------------------------------------------------------------------------
module serial_adder_ctrl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic [1:0]   state_o
);

  import serial_adder_ctrl_pkg::*;

  localparam int             CW   = cnt_width(W);
  localparam logic [CW-1:0]  LAST = CW'(W - 1);

  state_t         state_q;
  logic [W-1:0]   a_sr_q;
  logic [W-1:0]   b_sr_q;
  logic [W-1:0]   res_sr_q;
  logic [W-1:0]   res_sr_d;
  logic           carry_q;
  logic [CW-1:0]  cnt_q;
  logic           busy_q;
  logic           done_q;
  logic [W-1:0]   sum_q;
  logic           cout_q;
  logic           fs;
  logic           fc;

  full_adder u_fa (
    .sum  (fs),
    .cout (fc),
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q)
  );

  // New result bit enters at the MSB so that after W shifts bit 0 sits at
  // the LSB. Written this way to stay legal for W=1.
  always_comb begin
    res_sr_d        = res_sr_q >> 1;
    res_sr_d[W-1]   = fs;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sr_q  <= a;
            b_sr_q  <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          a_sr_q   <= a_sr_q >> 1;
          b_sr_q   <= b_sr_q >> 1;
          res_sr_q <= res_sr_d;
          carry_q  <= fc;
          if (cnt_q == LAST) begin
            // Last bit: publish result; counter parked at 0 so it never
            // exceeds W-1.
            cnt_q   <= '0;
            sum_q   <= res_sr_d;
            cout_q  <= fc;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign sum     = sum_q;
  assign cout    = cout_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_ctrl
//   Directed + randomized bench for serial_adder_ctrl at W=8 and W=1.
//   Reference: {cout,sum} = a + b + cin computed arithmetically; done is
//   expected W+1 edges after the start edge (start edge included).
// ---------------------------------------------------------------------------
module tb_serial_adder_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT W=8 ----------------
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic [1:0] st8;

  serial_adder_ctrl #(.W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .state_o(st8)
  );

  // ---------------- DUT W=1 ----------------
  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       cin1 = 1'b0;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;
  logic [1:0] st1;

  serial_adder_ctrl #(.W(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .state_o(st1)
  );

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;
  logic [8:0] exp_q[$];   // expected {cout,sum} for W=8 ops, in issue order
  logic [8:0] last8 = '0; // result the W=8 DUT must currently hold
  logic [1:0] last1 = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------- driver: one W=8 operation ----------------
  // pulse_at > 0 pulses a stray start (0x0F+0x01) at that RUN cycle.
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                      input int pulse_at, input string tag);
    int edges;
    int busy_cnt;
    logic [8:0] exp;
    exp_q.push_back({1'b0, ta} + {1'b0, tb} + {8'd0, tc});
    @(negedge clk);
    start8 = 1'b1; a8 = ta; b8 = tb; cin8 = tc;
    @(negedge clk);                       // start edge t0 has passed
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    edges = 1; busy_cnt = 0;
    while (!done8 && edges < 40) begin
      if (busy8) busy_cnt++;
      if (edges == 4) check({tag, " held"}, {55'd0, cout8, sum8}, {55'd0, last8});
      if (edges == pulse_at) begin
        start8 = 1'b1; a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0;
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk);
      edges++;
    end
    start8 = 1'b0;
    exp = exp_q.pop_front();
    check({tag, " latency"}, 64'(edges), 64'd9);
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd8);
    check({tag, " result"}, {55'd0, cout8, sum8}, {55'd0, exp});
    check({tag, " busy_with_done"}, {63'd0, busy8}, 64'd0);
    last8 = exp;
    @(negedge clk);
    check({tag, " done_pulse"}, {63'd0, done8}, 64'd0);
  endtask

  // ---------------- driver: one W=1 operation ----------------
  task automatic run1(input logic ta, input logic tb, input logic tc, input string tag);
    int edges;
    logic [1:0] exp;
    exp = {1'b0, ta} + {1'b0, tb} + {1'b0, tc};
    @(negedge clk);
    start1 = 1'b1; a1 = ta; b1 = tb; cin1 = tc;
    @(negedge clk);
    start1 = 1'b0;
    a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
    edges = 1;
    check({tag, " busy"}, {63'd0, busy1}, 64'd1);
    check({tag, " held"}, {62'd0, cout1, sum1}, {62'd0, last1});
    while (!done1 && edges < 20) begin
      @(negedge clk);
      edges++;
    end
    check({tag, " latency"}, 64'(edges), 64'd2);
    check({tag, " result"}, {62'd0, cout1, sum1}, {62'd0, exp});
    last1 = exp;
    @(negedge clk);
    check({tag, " done_pulse"}, {63'd0, done1}, 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int edges;
    int dones;

    // reset
    repeat (3) @(negedge clk);
    check("rst busy8", {63'd0, busy8}, 64'd0);
    check("rst done8", {63'd0, done8}, 64'd0);
    check("rst result8", {55'd0, cout8, sum8}, 64'd0);
    check("rst state8", {62'd0, st8}, 64'd0);
    check("rst result1", {62'd0, cout1, sum1}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // directed W=8
    run8(8'h00, 8'h00, 1'b0, 0, "zero");
    run8(8'hFF, 8'h01, 1'b0, 0, "ripple");
    run8(8'hA5, 8'h5A, 1'b1, 0, "a5_5a_c1");
    run8(8'h12, 8'h34, 1'b0, 0, "12_34");

    // stray start mid-RUN is dropped: one done only
    run8(8'h10, 8'h20, 1'b0, 3, "ignore_start");
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8) dones++;
      @(negedge clk);
    end
    check("ignore_start extra_done", 64'(dones), 64'd0);
    check("ignore_start result_kept", {55'd0, cout8, sum8}, 64'h030);

    // reset at the 4th RUN cycle
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h77; b8 = 8'h11; cin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst busy", {63'd0, busy8}, 64'd0);
    check("midrst done", {63'd0, done8}, 64'd0);
    check("midrst result", {55'd0, cout8, sum8}, 64'd0);
    last8 = '0;
    last1 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8 || busy8) dones++;
      @(negedge clk);
    end
    check("midrst no_activity", 64'(dones), 64'd0);
    run8(8'h03, 8'h04, 1'b0, 0, "after_rst");

    // back-to-back: start held high is accepted in the next IDLE
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h21; b8 = 8'h43; cin8 = 1'b1;
    edges = 0; dones = 0;
    for (int i = 0; i < 2 * 10 + 2; i++) begin
      @(negedge clk);
      edges++;
      if (done8) dones++;
    end
    start8 = 1'b0;
    check("b2b done_count", 64'(dones), 64'd2);
    check("b2b result", {55'd0, cout8, sum8}, 64'h065);
    last8 = 9'h065;
    repeat (12) @(negedge clk);

    // randomized W=8
    for (int i = 0; i < 20; i++) begin
      run8(8'($urandom), 8'($urandom), 1'($urandom_range(1, 0)), 0, "rand");
    end

    // W=1 exhaustive
    for (int i = 0; i < 8; i++) begin
      run1(i[2], i[1], i[0], "w1");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
